galinha_mov: RTL and testbench
==============================

GALINHA_MOV -- requirements
Module: galinha_mov

Interface
REQ-001 SHALL have parameter STEP, default 10, meaning pixels moved per accepted command.
REQ-002 SHALL have parameter HOLD, default 2500000, meaning cooldown clock cycles after each step.
REQ-003 SHALL have parameter COL_MAX, default 610, meaning highest allowed column position (sprite width 30 inside 640).
REQ-004 SHALL have parameter ROW_MAX, default 450, meaning highest allowed row position (sprite height 30 inside 480).
REQ-005 SHALL have parameter DEB, default 250000, meaning debounce stability cycles (used only with the debounce macro).
REQ-006 SHALL have port clk input 1: the single clock, all logic on its rising edge.
REQ-007 SHALL have port nrst input 1: synchronous active-low reset.
REQ-008 SHALL have port dir input 4: direction code: 0011 forward, 1100 down, 0001 back, 0100 up; any other value means no command.
REQ-009 SHALL have port column_en output 1: column counter step enable to the sprite block.
REQ-010 SHALL have port column_updown output 1: 1 = increment column, 0 = decrement.
REQ-011 SHALL have port row_en output 1: row counter step enable.
REQ-012 SHALL have port row_updown output 1: 1 = increment row, 0 = decrement.
REQ-013 SHALL have port col_pos output 10: shadow of sprite column count.
REQ-014 SHALL have port row_pos output 10: shadow of sprite row count.
REQ-015 SHALL have port busy output 1: high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, STEP and COOL.
REQ-017 In IDLE with a valid dir, SHALL latch the code, compute the step count n, and enter STEP on the next edge.
- Forward: n = min(STEP, COL_MAX - col_pos).
- Back: n = min(STEP, col_pos).
- Down: n = min(STEP, ROW_MAX - row_pos).
- Up: n = min(STEP, row_pos).
REQ-018 If n = 0 (already at the border), SHALL go directly to COOL with no enable pulses.
REQ-019 In STEP, SHALL assert exactly one enable (column_en for forward/back, row_en for down/up) for exactly n consecutive cycles, then enter COOL.
REQ-020 SHALL drive updown to 1 for forward/down and 0 for back/up, held for the whole STEP; updown SHALL be 0 whenever its enable is low.
REQ-021 SHALL update col_pos/row_pos by ±1 on every cycle the matching enable is high, so they track the sprite count exactly.
REQ-022 SHALL never move col_pos outside 0..COL_MAX or row_pos outside 0..ROW_MAX; sprite wrap-around SHALL therefore never be triggered.
REQ-023 SHALL ignore dir changes during STEP and COOL; the latched code governs the step.
REQ-024 SHALL stay in COOL for exactly HOLD cycles, then return to IDLE; a dir held valid repeats one step per STEP+HOLD+1 cycles.
REQ-025 SHALL never assert column_en and row_en in the same cycle.
REQ-026 SHALL keep all outputs registered, with no combinational path from dir to any output.

Reset
REQ-027 While nrst = 0 at a clock edge, SHALL force state IDLE, all enables and updowns 0, col_pos 0, row_pos 0, busy 0, and clear counters and the latched code.
REQ-028 A reset asserted mid-STEP SHALL stop pulses on the same edge; no partial step resumes after release.
REQ-029 The first command SHALL be accepted no earlier than the first edge after nrst returns high.

Configuration
REQ-030 Macro GALINHA_MOV_DEBOUNCE_EN, when defined, SHALL require dir to stay at the same valid code for DEB consecutive cycles before IDLE accepts it; any change restarts the count, and the count clears on reset.
REQ-031 Without GALINHA_MOV_DEBOUNCE_EN, SHALL accept a valid dir on the first IDLE cycle it is seen; DEB is then unused.

Verification
(All scenarios use STEP=3, HOLD=4, COL_MAX=6, ROW_MAX=6, DEB=2.)
REQ-032 Reset, then dir=0011 held for one command → column_en high 3 cycles, column_updown=1, col_pos=3, busy high 3+4 cycles.
REQ-033 col_pos=5, dir=0011 → exactly 1 column_en pulse, col_pos=6; next command gives 0 pulses and 4 busy cooldown cycles.
REQ-034 row_pos=0, dir=0100 → no row_en, row_pos stays 0; then dir=1100 held → row_pos goes 3, then 6, with steps 8 cycles apart.
REQ-035 dir=1010 or 0000 → busy stays 0, all enables stay 0.
REQ-036 nrst low on the 2nd STEP cycle → enables drop at that edge, positions 0, IDLE; col_en/row_en never both high in any scenario.
REQ-037 With GALINHA_MOV_DEBOUNCE_EN, dir=0011 for 1 cycle → no move; dir=0011 for 2 or more cycles → move. Without the macro, a 1-cycle pulse → move.

Source files
------------

// File: rtl/galinha_mov.sv
`timescale 1ns/1ps
// galinha_mov: turns a 4-bit direction code into a burst of step-enable
// pulses for the sprite column/row counters, clamped at the screen border,
// followed by a cooldown. Shadow positions track the sprite counters.
// Optional macro GALINHA_MOV_DEBOUNCE_EN: dir must hold the same valid code
// for DEB consecutive cycles before it is accepted.
module galinha_mov #(
    parameter int STEP    = 10,
    parameter int HOLD    = 2500000,
    parameter int COL_MAX = 610,
    parameter int ROW_MAX = 450,
    parameter int DEB     = 250000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] dir,
    output logic       column_en,
    output logic       column_updown,
    output logic       row_en,
    output logic       row_updown,
    output logic [9:0] col_pos,
    output logic [9:0] row_pos,
    output logic       busy
);

    localparam logic [3:0] D_FWD  = 4'b0011;
    localparam logic [3:0] D_DOWN = 4'b1100;
    localparam logic [3:0] D_BACK = 4'b0001;
    localparam logic [3:0] D_UP   = 4'b0100;

    localparam logic [9:0] STEP_V = 10'(STEP);
    localparam logic [9:0] CMAX   = 10'(COL_MAX);
    localparam logic [9:0] RMAX   = 10'(ROW_MAX);

    // Cooldown counter counts HOLD-1 down to 0, giving HOLD cycles in COOL.
    localparam int         HW      = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD - 1);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_COOL} state_t;

    state_t        state, state_nxt;
    logic [3:0]    code, code_nxt;
    logic [9:0]    cnt, cnt_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          col_en_nxt, col_ud_nxt, row_en_nxt, row_ud_nxt;

    logic          dir_ok, dir_col, dir_inc, code_col, code_inc;
    logic          accept;
    logic [9:0]    room, n_calc;

    assign dir_ok   = (dir == D_FWD) || (dir == D_DOWN) || (dir == D_BACK) || (dir == D_UP);
    assign dir_col  = (dir == D_FWD) || (dir == D_BACK);
    assign dir_inc  = (dir == D_FWD) || (dir == D_DOWN);
    assign code_col = (code == D_FWD) || (code == D_BACK);
    assign code_inc = (code == D_FWD) || (code == D_DOWN);

    // Distance to the border in the requested direction, clamped to STEP.
    always_comb begin
        room = 10'd0;
        case (dir)
            D_FWD:   room = CMAX - col_pos;
            D_BACK:  room = col_pos;
            D_DOWN:  room = RMAX - row_pos;
            D_UP:    room = row_pos;
            default: room = 10'd0;
        endcase
        n_calc = (room < STEP_V) ? room : STEP_V;
    end

`ifdef GALINHA_MOV_DEBOUNCE_EN
    localparam int         DW    = (DEB > 0) ? $clog2(DEB + 1) : 1;
    localparam logic [DW-1:0] DEB_V = DW'(DEB);

    logic [3:0]    dir_prev;
    logic [DW-1:0] stab, stab_nxt;

    // Consecutive-cycle count of the same valid code, saturating at DEB.
    always_comb begin
        stab_nxt = '0;
        if (dir_ok) begin
            if (dir == dir_prev)
                stab_nxt = (stab >= DEB_V) ? stab : stab + 1'b1;
            else
                stab_nxt = DW'(1);
        end
        accept = dir_ok && (stab_nxt >= DEB_V);
    end

    // Stability tracker registers; runs in every state so a held code
    // repeats immediately after cooldown.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            dir_prev <= 4'd0;
            stab     <= '0;
        end else begin
            dir_prev <= dir;
            stab     <= stab_nxt;
        end
    end
`else
    // DEB has no effect in this build.
    assign accept = dir_ok && (DEB >= 0);
`endif

    // Next-state and next-output logic; enables are registered from here.
    always_comb begin
        state_nxt  = state;
        code_nxt   = code;
        cnt_nxt    = cnt;
        hold_nxt   = hold_cnt;
        col_en_nxt = 1'b0;
        col_ud_nxt = 1'b0;
        row_en_nxt = 1'b0;
        row_ud_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    code_nxt = dir;
                    if (n_calc == 10'd0) begin
                        state_nxt = S_COOL;
                        hold_nxt  = HOLD_LD;
                    end else begin
                        state_nxt  = S_STEP;
                        cnt_nxt    = n_calc;
                        col_en_nxt = dir_col;
                        col_ud_nxt = dir_col & dir_inc;
                        row_en_nxt = !dir_col;
                        row_ud_nxt = !dir_col & dir_inc;
                    end
                end
            end
            S_STEP: begin
                // cnt holds the pulses left including the one now on the output
                if (cnt <= 10'd1) begin
                    state_nxt = S_COOL;
                    cnt_nxt   = 10'd0;
                    hold_nxt  = HOLD_LD;
                end else begin
                    cnt_nxt    = cnt - 10'd1;
                    col_en_nxt = code_col;
                    col_ud_nxt = code_col & code_inc;
                    row_en_nxt = !code_col;
                    row_ud_nxt = !code_col & code_inc;
                end
            end
            S_COOL: begin
                if (hold_cnt == '0)
                    state_nxt = S_IDLE;
                else
                    hold_nxt = hold_cnt - 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state         <= S_IDLE;
            code          <= 4'd0;
            cnt           <= 10'd0;
            hold_cnt      <= '0;
            column_en     <= 1'b0;
            column_updown <= 1'b0;
            row_en        <= 1'b0;
            row_updown    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            code          <= code_nxt;
            cnt           <= cnt_nxt;
            hold_cnt      <= hold_nxt;
            column_en     <= col_en_nxt;
            column_updown <= col_ud_nxt;
            row_en        <= row_en_nxt;
            row_updown    <= row_ud_nxt;
            busy          <= (state_nxt != S_IDLE);
        end
    end

    // Shadow positions follow the sprite counters one step per enable cycle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            col_pos <= 10'd0;
            row_pos <= 10'd0;
        end else begin
            if (column_en)
                col_pos <= column_updown ? col_pos + 10'd1 : col_pos - 10'd1;
            if (row_en)
                row_pos <= row_updown ? row_pos + 10'd1 : row_pos - 10'd1;
        end
    end

endmodule

// File: tb/tb_galinha_mov.sv
`timescale 1ns/1ps
// Directed bench for galinha_mov (STEP=3, HOLD=4, max 6/6, DEB=2) plus a
// second instance with max 5/5 so partial (clamped) steps are exercised.
module tb_galinha_mov;

    localparam logic [3:0] D_FWD  = 4'b0011;
    localparam logic [3:0] D_DOWN = 4'b1100;
    localparam logic [3:0] D_BACK = 4'b0001;
    localparam logic [3:0] D_UP   = 4'b0100;
`ifdef GALINHA_MOV_DEBOUNCE_EN
    localparam int ACC = 2;
`else
    localparam int ACC = 1;
`endif

    logic       clk, nrst;
    logic [3:0] dir;
    logic       column_en, column_updown, row_en, row_updown, busy;
    logic [9:0] col_pos, row_pos;
    logic       c_column_en, c_column_updown, c_row_en, c_row_updown, c_busy;
    logic [9:0] c_col_pos, c_row_pos;

    int n_assert = 0;
    int n_fail   = 0;
    int col_p = 0, row_p = 0, ccol_p = 0, crow_p = 0;
    int t3, t6;

    galinha_mov #(.STEP(3), .HOLD(4), .COL_MAX(6), .ROW_MAX(6), .DEB(2)) u_dut (
        .clk(clk), .nrst(nrst), .dir(dir),
        .column_en(column_en), .column_updown(column_updown),
        .row_en(row_en), .row_updown(row_updown),
        .col_pos(col_pos), .row_pos(row_pos), .busy(busy));

    galinha_mov #(.STEP(3), .HOLD(4), .COL_MAX(5), .ROW_MAX(5), .DEB(2)) u_clip (
        .clk(clk), .nrst(nrst), .dir(dir),
        .column_en(c_column_en), .column_updown(c_column_updown),
        .row_en(c_row_en), .row_updown(c_row_updown),
        .col_pos(c_col_pos), .row_pos(c_row_pos), .busy(c_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and the never-both-enables check, sampled mid-cycle.
    always @(negedge clk) begin
        if (column_en)   col_p++;
        if (row_en)      row_p++;
        if (c_column_en) ccol_p++;
        if (c_row_en)    crow_p++;
        n_assert++;
        assert (!(column_en && row_en) && !(c_column_en && c_row_en))
        else begin
            n_fail++;
            $error("FAIL both_en: got %b%b/%b%b expected no pair high",
                   column_en, row_en, c_column_en, c_row_en);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic zero_counts();
        col_p = 0; row_p = 0; ccol_p = 0; crow_p = 0;
    endtask

    // Present a code long enough to be accepted; returns just after the
    // accepting edge.
    task automatic cmd(input logic [3:0] code);
        dir = code;
        repeat (ACC) tick();
        dir = 4'b0000;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || c_busy) && k < 100) begin
            tick();
            k++;
        end
        chk("idle_timeout", 32'(busy | c_busy), 0);
    endtask

    initial begin
        nrst = 1'b0;
        dir  = 4'b0000;
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_en", 32'({column_en, row_en, column_updown, row_updown}), 0);
        chk("rst_col", 32'(col_pos), 0);
        chk("rst_row", 32'(row_pos), 0);

        nrst = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // One forward step, cycle-exact
        cmd(D_FWD);
        for (int i = 0; i < 3; i++) begin
            chk("fwd_en", 32'(column_en), 1);
            chk("fwd_ud", 32'(column_updown), 1);
            chk("fwd_row_en", 32'(row_en), 0);
            chk("fwd_busy", 32'(busy), 1);
            chk("fwd_pos", 32'(col_pos), 32'(i));
            tick();
        end
        chk("fwd_en_off", 32'(column_en), 0);
        chk("fwd_ud_off", 32'(column_updown), 0);
        chk("fwd_pos3", 32'(col_pos), 3);
        for (int i = 0; i < 4; i++) begin
            chk("cool_busy", 32'(busy), 1);
            tick();
        end
        chk("cool_done", 32'(busy), 0);

        // Second forward: full step on main, clamped to 2 on the clip instance
        zero_counts();
        cmd(D_FWD);
        wait_idle();
        chk("fwd2_pos", 32'(col_pos), 6);
        chk("fwd2_pulses", 32'(col_p), 3);
        chk("clip_pos", 32'(c_col_pos), 5);
        chk("clip_pulses", 32'(ccol_p), 2);

        // At the border: no pulses, exactly 4 cooldown cycles
        zero_counts();
        cmd(D_FWD);
        for (int i = 0; i < 4; i++) begin
            chk("edge_busy", 32'(busy), 1);
            chk("edge_en", 32'(column_en), 0);
            tick();
        end
        chk("edge_done", 32'(busy), 0);
        chk("edge_pulses", 32'(col_p + ccol_p), 0);
        chk("edge_pos", 32'(col_pos), 6);

        // Up from row 0: no move
        zero_counts();
        cmd(D_UP);
        chk("up_busy", 32'(busy), 1);
        wait_idle();
        chk("up_row", 32'(row_pos), 0);
        chk("up_pulses", 32'(row_p), 0);

        // Down held: 3 then 6, eight cycles apart; clip stops at 5
        zero_counts();
        t3 = -1;
        t6 = -1;
        dir = D_DOWN;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (row_pos == 10'd3 && t3 < 0) t3 = k;
            if (row_pos == 10'd6 && t6 < 0) t6 = k;
        end
        dir = 4'b0000;
        wait_idle();
        chk("down_t3_seen", 32'(t3 > 0), 1);
        chk("down_period", 32'(t6 - t3), 8);
        chk("down_row", 32'(row_pos), 6);
        chk("down_pulses", 32'(row_p), 6);
        chk("clip_row", 32'(c_row_pos), 5);
        chk("clip_row_pulses", 32'(crow_p), 5);

        // Invalid codes do nothing
        dir = 4'b1010;
        repeat (3) begin
            tick();
            chk("inv_busy", 32'(busy), 0);
            chk("inv_en", 32'(column_en | row_en), 0);
        end
        dir = 4'b0000;
        repeat (3) begin
            tick();
            chk("zero_busy", 32'(busy | c_busy), 0);
            chk("zero_en", 32'(column_en | row_en), 0);
        end

        // Reset in the 2nd STEP cycle of a back move
        zero_counts();
        cmd(D_BACK);
        chk("back_en", 32'(column_en), 1);
        chk("back_ud", 32'(column_updown), 0);
        chk("back_pos", 32'(col_pos), 6);
        tick();
        chk("back_en2", 32'(column_en), 1);
        chk("back_pos2", 32'(col_pos), 5);
        nrst = 1'b0;
        tick();
        chk("mid_rst_en", 32'(column_en | row_en), 0);
        chk("mid_rst_col", 32'(col_pos), 0);
        chk("mid_rst_row", 32'(row_pos), 0);
        chk("mid_rst_busy", 32'(busy | c_busy), 0);
        tick();
        nrst = 1'b1;
        repeat (6) begin
            tick();
            chk("post_rst_idle", 32'(busy | column_en), 0);
        end
        chk("post_rst_pos", 32'(col_pos), 0);
        chk("back_pulses", 32'(col_p), 2);

        // Single-cycle pulse on dir
`ifdef GALINHA_MOV_DEBOUNCE_EN
        dir = D_FWD;
        tick();
        dir = 4'b0000;
        repeat (3) tick();
        chk("pulse_ignored", 32'(busy), 0);
        chk("pulse_pos", 32'(col_pos), 0);
        cmd(D_FWD);
        chk("held_moves", 32'(column_en), 1);
`else
        dir = D_FWD;
        tick();
        dir = 4'b0000;
        chk("pulse_moves", 32'(column_en), 1);
        chk("pulse_busy", 32'(busy), 1);
`endif
        wait_idle();
        chk("pulse_pos3", 32'(col_pos), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
